uart_tx_frame: RTL and testbench

Configurable-frame UART transmitter, successor to the fixed 8N1 transmitter. It supports runtime-selectable data width, parity mode, stop-bit count and line break. A one-entry holding buffer with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the TX FIFO read side and the pad, paced by the baud generator's txClk tick on `en`.

---
 rtl/uart_tx_frame.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// uart_tx_frame : configurable-frame UART transmitter (5..9 data bits, parity,
//                 1/2 stop bits, line break) with a one-entry holding buffer.
// Revision      : 1.0
// ============================================================================
module uart_tx_frame #(
  parameter int MAX_DATA_BITS = 9,
  parameter int CNT_W         = $clog2(MAX_DATA_BITS + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     en,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  input  logic                     cfg_break,
  input  logic [MAX_DATA_BITS-1:0] wdata,
  input  logic                     wvalid,
  output logic                     wready,
  output logic                     tx_out,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam logic [3:0]       c_MIN_BITS = 4'd5;
  localparam logic [3:0]       c_MAX_BITS = 4'(MAX_DATA_BITS);
  localparam logic [1:0]       c_PAR_NONE = 2'b00;
  localparam logic [1:0]       c_PAR_EVEN = 2'b01;
  localparam logic [1:0]       c_PAR_ODD  = 2'b10;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  state_t                   r_state;
  logic [MAX_DATA_BITS-1:0] r_buf;
  logic                     r_buf_full;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_tx;
  logic                     r_done;
  logic                     r_par_bit;
  logic                     r_par_en;
  logic                     r_stop2;
  logic                     r_brk_stop;

  logic [3:0]               w_eff_bits;
  logic [MAX_DATA_BITS-1:0] w_mask;
  logic [MAX_DATA_BITS-1:0] w_load;
  logic                     w_par_bit;
  logic                     w_at_rest;

  assign cfg_err    = (cfg_data_bits < c_MIN_BITS) || (cfg_data_bits > c_MAX_BITS);
  assign w_eff_bits = (cfg_data_bits < c_MIN_BITS) ? c_MIN_BITS :
                      (cfg_data_bits > c_MAX_BITS) ? c_MAX_BITS : cfg_data_bits;

  for (genvar i = 0; i < MAX_DATA_BITS; i++) begin : g_mask
    assign w_mask[i] = (4'(i) < w_eff_bits);
  end

  assign w_load = r_buf & w_mask;

  always_comb begin
    w_par_bit = 1'b1;
    case (cfg_parity)
      c_PAR_EVEN: w_par_bit = ^w_load;
      c_PAR_ODD:  w_par_bit = ~(^w_load);
      default:    w_par_bit = 1'b1;
    endcase
  end

  // Idle and the final stop bit share one decision: break, next frame, or idle.
  assign w_at_rest = (r_state == S_IDLE) || (r_state == S_STOP2) ||
                     ((r_state == S_STOP1) && !r_stop2);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_brk_stop <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (wvalid && !r_buf_full) begin
        r_buf      <= wdata;
        r_buf_full <= 1'b1;
      end
      if (en) begin
        if (w_at_rest) begin
          if (r_state != S_IDLE) begin
            r_done <= !r_brk_stop;
          end
          if (cfg_break) begin
            r_state <= S_BREAK;
            r_tx    <= 1'b0;
          end else if (r_buf_full) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_buf_full <= 1'b0;
            r_shift    <= w_load;
            r_cnt      <= w_eff_bits[CNT_W-1:0];
            r_par_bit  <= w_par_bit;
            r_par_en   <= (cfg_parity != c_PAR_NONE);
            r_stop2    <= cfg_stop2;
            r_brk_stop <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        end else begin
          case (r_state)
            S_START: begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
            end
            S_DATA: begin
              if (r_cnt == c_CNT_ONE) begin
                if (r_par_en) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par_bit;
                end else begin
                  r_state <= S_STOP1;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt - c_CNT_ONE;
                r_tx    <= r_shift[1];
              end
            end
            S_PARITY: begin
              r_state <= S_STOP1;
              r_tx    <= 1'b1;
            end
            S_STOP1: begin
              r_state <= S_STOP2;
              r_tx    <= 1'b1;
            end
            S_BREAK: begin
              // Break exit inserts a single stop bit that never signals done.
              if (!cfg_break) begin
                r_state    <= S_STOP1;
                r_tx       <= 1'b1;
                r_stop2    <= 1'b0;
                r_brk_stop <= 1'b1;
              end else begin
                r_tx <= 1'b0;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign wready = !r_buf_full;
  assign busy   = (r_state != S_IDLE) || r_buf_full;
  assign tx_out = r_tx;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// tb_uart_tx_frame : vector table, hand sequences and randomized frames checked
// against a frame-level model of the serial line.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       en = 1'b0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       cfg_break = 1'b0;
  logic [8:0] wdata = '0;
  logic       wvalid = 1'b0;
  logic       wready, tx_out, busy, done, cfg_err;

  uart_tx_frame #(.MAX_DATA_BITS(9)) dut (
    .CLK(CLK), .nRST(nRST), .en(en),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .cfg_break(cfg_break),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .tx_out(tx_out), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int en_div = 4;
  int div_cnt = 0;
  always @(negedge CLK) begin
    if (div_cnt + 1 >= en_div) div_cnt = 0;
    else div_cnt = div_cnt + 1;
    en = (div_cnt == 0);
  end

  typedef struct { logic tx; logic dn; int cyc; } ent_t;
  ent_t line_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (en) line_q.push_back('{tx_out, done, cyc});
    if (done) done_cnt++;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout, event not seen, required within budget", nm);
  endtask

  // Frame as seen on the line: start, masked data LSB first, optional parity, stops.
  function automatic void model_frame(input logic [8:0] w, input logic [3:0] raw,
                                      input logic [1:0] par, input logic s2,
                                      output logic [31:0] bits, output int len);
    int wid;
    int ones;
    bit q[$];
    wid  = (raw < 5) ? 5 : ((raw > 9) ? 9 : int'(raw));
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < wid; i++) begin
      q.push_back(w[i]);
      ones += int'(w[i]);
    end
    case (par)
      2'b01: q.push_back((ones % 2) == 1);
      2'b10: q.push_back((ones % 2) == 0);
      2'b11: q.push_back(1'b1);
      default: ;
    endcase
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    bits = '0;
    len  = q.size();
    for (int i = 0; i < len; i++) bits[i] = q[i];
  endfunction

  function automatic int find_start();
    int s;
    s = -1;
    for (int i = 0; i < line_q.size(); i++)
      if (s < 0 && line_q[i].tx == 1'b0) s = i;
    return s;
  endfunction

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 5000) begin @(negedge CLK); t++; end
    if (busy !== 1'b0) fail_timeout({nm, "_idle"});
  endtask

  task automatic wait_done(input string nm, input int n, input int budget);
    int t;
    t = 0;
    while (done_cnt < n && t < budget) begin @(negedge CLK); t++; end
    if (done_cnt < n) fail_timeout({nm, "_done"});
  endtask

  task automatic wait_entries(input string nm, input int n, input int budget);
    int t;
    t = 0;
    while (line_q.size() < n && t < budget) begin @(negedge CLK); t++; end
    if (line_q.size() < n) fail_timeout({nm, "_periods"});
  endtask

  task automatic wait_start(input string nm, output int s);
    int t;
    t = 0;
    s = find_start();
    while (s < 0 && t < 2000) begin @(negedge CLK); t++; s = find_start(); end
    if (s < 0) begin fail_timeout({nm, "_start"}); s = 0; end
  endtask

  task automatic write_word(input string nm, input logic [8:0] w);
    int t;
    t = 0;
    while (!wready && t < 2000) begin @(negedge CLK); t++; end
    if (!wready) fail_timeout({nm, "_wready"});
    wdata  = w;
    wvalid = 1'b1;
    @(negedge CLK);
    wvalid = 1'b0;
  endtask

  task automatic check_line(input string nm, input logic [31:0] eb, input int elen,
                            input int edones, input int dpos, input int div);
    int s, nd, lastd;
    logic [31:0] got;
    s = find_start();
    nd = 0;
    lastd = -1;
    got = '0;
    if (s < 0 || line_q.size() < s + elen + 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_frame: got %0d line periods, required start plus %0d", nm,
               line_q.size(), elen + 1);
    end else begin
      for (int i = 0; i < elen; i++) got[i] = line_q[s + i].tx;
      check({nm, "_bits"}, got, eb);
      for (int i = 0; i < line_q.size(); i++)
        if (line_q[i].dn) begin nd++; lastd = i; end
      check({nm, "_dones"}, 32'(nd), 32'(edones));
      check({nm, "_done_pos"}, 32'(lastd - s), 32'(dpos));
      if (lastd >= 0)
        check({nm, "_cycles"}, 32'(line_q[lastd].cyc - line_q[s].cyc), 32'(dpos * div));
    end
  endtask

  task automatic run_frame(input string nm, input logic [8:0] w, input logic [3:0] b,
                           input logic [1:0] p, input logic s2, input int div,
                           input logic [31:0] eb, input int elen, input logic eerr);
    wait_idle(nm);
    @(negedge CLK);
    cfg_data_bits = b;
    cfg_parity    = p;
    cfg_stop2     = s2;
    en_div        = div;
    #1;
    check({nm, "_cfg_err"}, 32'(cfg_err), 32'(eerr));
    line_q.delete();
    done_cnt = 0;
    write_word(nm, w);
    wait_done(nm, 1, 20 * 16 * div + 100);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    check_line(nm, eb, elen, 1, elen, div);
  endtask

  typedef struct {
    logic [8:0]  w;
    logic [3:0]  bits;
    logic [1:0]  par;
    logic        s2;
    int          div;
    logic [31:0] eb;
    int          elen;
    logic        eerr;
  } vec_t;

  vec_t        tbl[6];
  int          s;
  int          t;
  int          el, el2;
  logic [31:0] eb, eb2;
  logic [8:0]  rw;
  logic [3:0]  rb;
  logic [1:0]  rp;
  logic        rs;
  int          rd;
  int          started;

  initial begin
    tbl[0] = '{9'h0A5, 4'd8,  2'b00, 1'b0, 16, 32'h34A, 10, 1'b0};
    tbl[1] = '{9'h0A5, 4'd8,  2'b01, 1'b0, 3,  32'h54A, 11, 1'b0};
    tbl[2] = '{9'h041, 4'd7,  2'b10, 1'b1, 3,  32'h782, 11, 1'b0};
    tbl[3] = '{9'h1F3, 4'd3,  2'b00, 1'b0, 2,  32'h066, 7,  1'b1};
    tbl[4] = '{9'h155, 4'd12, 2'b11, 1'b0, 2,  32'hEAA, 12, 1'b1};
    tbl[5] = '{9'h1FF, 4'd6,  2'b01, 1'b1, 1,  32'h37E, 10, 1'b0};

    repeat (3) @(negedge CLK);
    check("reset_tx", 32'(tx_out), 32'd1);
    check("reset_wready", 32'(wready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_reset_tx", 32'(tx_out), 32'd1);

    for (int k = 0; k < 6; k++)
      run_frame($sformatf("vec%0d", k), tbl[k].w, tbl[k].bits, tbl[k].par, tbl[k].s2,
                tbl[k].div, tbl[k].eb, tbl[k].elen, tbl[k].eerr);

    // Back-to-back: second word held until the first frame's START frees the buffer.
    wait_idle("b2b");
    @(negedge CLK);
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0; en_div = 4;
    line_q.delete(); done_cnt = 0;
    write_word("b2b", 9'h055);
    check("b2b_wready_full", 32'(wready), 32'd0);
    wdata = 9'h0AA; wvalid = 1'b1; t = 0;
    while (!wready && t < 400) begin @(negedge CLK); t++; end
    started = (find_start() >= 0) ? 1 : 0;
    check("b2b_wready_after_start", 32'(started), 32'd1);
    @(negedge CLK);
    wvalid = 1'b0;
    wait_done("b2b", 2, 2000);
    model_frame(9'h055, 4'd8, 2'b00, 1'b0, eb, el);
    model_frame(9'h0AA, 4'd8, 2'b00, 1'b0, eb2, el2);
    check_line("b2b", eb | (eb2 << el), el + el2, 2, el + el2, 4);

    // Break from idle with a word pending: 5 break periods, 1 stop, then the frame.
    wait_idle("brk");
    @(negedge CLK);
    line_q.delete(); done_cnt = 0;
    cfg_break = 1'b1;
    write_word("brk", 9'h0FF);
    wait_start("brk", s);
    wait_entries("brk", s + 5, 200);
    cfg_break = 1'b0;
    wait_done("brk", 1, 2000);
    wait_idle("brk");
    check_line("brk", 32'hFFA0, 16, 1, 16, 4);

    // Config changed mid-frame must not affect the frame in flight.
    @(negedge CLK);
    line_q.delete(); done_cnt = 0;
    write_word("midcfg", 9'h0A5);
    wait_start("midcfg", s);
    wait_entries("midcfg", s + 2, 200);
    cfg_parity = 2'b10; cfg_stop2 = 1'b1; cfg_data_bits = 4'd5;
    wait_done("midcfg", 1, 2000);
    check_line("midcfg", 32'h34A, 10, 1, 10, 4);
    wait_idle("midcfg");
    @(negedge CLK);
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_data_bits = 4'd8;

    // Break requested mid-frame starts only after the stop bit.
    line_q.delete(); done_cnt = 0;
    write_word("midbrk", 9'h0A5);
    wait_start("midbrk", s);
    wait_entries("midbrk", s + 3, 200);
    cfg_break = 1'b1;
    wait_entries("midbrk", s + 13, 400);
    cfg_break = 1'b0;
    wait_entries("midbrk", s + 15, 400);
    wait_idle("midbrk");
    check_line("midbrk", 32'h234A, 14, 1, 10, 4);

    // Asynchronous reset in the middle of DATA with a second word buffered.
    @(negedge CLK);
    en_div = 8;
    line_q.delete(); done_cnt = 0;
    write_word("rst", 9'h0A5);
    wait_start("rst", s);
    write_word("rst2", 9'h0AA);
    wait_entries("rst", s + 3, 200);
    check("rst_pre_tx", 32'(tx_out), 32'd0);
    check("rst_pre_wready", 32'(wready), 32'd0);
    #2 nRST = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_out), 32'd1);
    check("rst_async_wready", 32'(wready), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    model_frame(9'h03C, 4'd8, 2'b00, 1'b0, eb, el);
    run_frame("post_rst", 9'h03C, 4'd8, 2'b00, 1'b0, 4, eb, el, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rw = 9'($urandom_range(0, 511));
      rb = 4'($urandom_range(0, 15));
      rp = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      rd = int'($urandom_range(1, 4));
      model_frame(rw, rb, rp, rs, eb, el);
      run_frame($sformatf("rnd%0d", k), rw, rb, rp, rs, rd, eb, el, (rb < 5) || (rb > 9));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
